mem_port_arbiter: RTL and testbench

Shares one unified single-port memory between the instruction-fetch stage and the memory (load/store) stage of the RISC-V pipeline. It accepts one request at a time, forwards it to the memory port with a req/gnt/rvalid handshake, returns the response to the winning requester and drives per-requester stall signals to the hazard logic. Data accesses have priority, and an anti-starvation counter guarantees fetch progress.

---
 rtl/mem_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// and the load/store stage. One transaction is outstanding at a time. Data
// accesses win arbitration, but after MAX_D_STREAK data grants in a row with a
// fetch waiting, the fetch is served. Responses are passed straight through
// from the memory and qualified by per-requester valid pulses.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  // instruction fetch requester
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_valid,
  output logic                i_stall,
  // load/store requester
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_valid,
  output logic                d_stall,
  // memory port
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                protocol_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD_I,
    S_CMD_D,
    S_WAIT_I,
    S_WAIT_D
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  state_t              r_state;
  logic [3:0]          r_streak;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W/8-1:0] r_mem_wstrb;
  logic                r_protocol_err;

  // Arbitration: data first, unless a waiting fetch has seen a full streak.
  logic w_streak_full;
  logic w_grant_d;
  logic w_grant_i;
  logic w_in_wait;

  assign w_streak_full = (r_streak == STREAK_MAX);
  assign w_grant_d     = d_req && !(i_req && w_streak_full);
  assign w_grant_i     = !w_grant_d && i_req;
  assign w_in_wait     = (r_state == S_WAIT_I) || (r_state == S_WAIT_D);

  // Responses are combinational so the requester sees data in the rvalid cycle.
  assign i_valid = (r_state == S_WAIT_I) && mem_rvalid;
  assign d_valid = (r_state == S_WAIT_D) && mem_rvalid;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;
  assign i_stall = i_req && !i_valid;
  assign d_stall = d_req && !d_valid;

  assign mem_req      = r_mem_req;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign mem_wstrb    = r_mem_wstrb;
  assign protocol_err = r_protocol_err;

  // Transaction FSM: grant, latch command, hold it until gnt, wait for rvalid.
  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; blocking = would let later lines see new state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_streak       <= '0;
      r_mem_req      <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_mem_wstrb    <= '0;
      r_protocol_err <= 1'b0;
    end else begin
      if (mem_rvalid && !w_in_wait) begin
        r_protocol_err <= 1'b1;
      end

      unique case (r_state)
        S_IDLE: begin
          if (w_grant_d) begin
            r_state     <= S_CMD_D;
            r_mem_req   <= 1'b1;
            r_mem_we    <= d_we;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_wdata;
            r_mem_wstrb <= d_wstrb;
            if (!i_req) begin
              r_streak <= '0;
            end else if (!w_streak_full) begin
              r_streak <= r_streak + 4'd1;
            end
          end else if (w_grant_i) begin
            r_state     <= S_CMD_I;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= i_addr;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
            r_streak    <= '0;
          end
        end
        S_CMD_I: begin
          if (mem_gnt) begin
            r_state   <= S_WAIT_I;
            r_mem_req <= 1'b0;
          end
        end
        S_CMD_D: begin
          if (mem_gnt) begin
            r_state   <= S_WAIT_D;
            r_mem_req <= 1'b0;
          end
        end
        S_WAIT_I,
        S_WAIT_D: begin
          if (mem_rvalid) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a behavioural memory with programmable grant and
// response delays, directed requester stimulus, and a scoreboard queue that a
// monitor drains on every i_valid/d_valid pulse.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_valid;
  logic          i_stall;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [3:0]    d_wstrb;
  logic [DW-1:0] d_rdata;
  logic          d_valid;
  logic          d_stall;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wstrb;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          protocol_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .protocol_err(protocol_err)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    bit          is_d;
    bit          chk_data;
    logic [31:0] rdata;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_exp(input bit is_d, input bit chk, input logic [31:0] rdata, input string name);
    exp_t e;
    e.is_d = is_d; e.chk_data = chk; e.rdata = rdata; e.name = name;
    exp_q.push_back(e);
  endtask

  // Monitor: every response pulse must match the next expected transaction.
  always @(negedge clk) begin
    if (!rst && (i_valid || d_valid)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_valid: i_valid=%0b d_valid=%0b with nothing expected", i_valid, d_valid);
      end else begin
        mon_e = exp_q.pop_front();
        check({mon_e.name, "_is_data"}, {31'b0, d_valid}, {31'b0, mon_e.is_d});
        check({mon_e.name, "_one_valid"}, {31'b0, i_valid & d_valid}, 32'd0);
        if (mon_e.chk_data)
          check({mon_e.name, "_rdata"}, d_valid ? d_rdata : i_rdata, mon_e.rdata);
      end
    end
  end

  // ---------------- memory model ----------------
  int            gnt_delay = 0;
  int            rv_delay  = 0;
  int            phase     = 0;
  int            cnt       = 0;
  logic          m_rv;
  logic          spur_rv = 1'b0;
  logic [31:0]   c_addr, c_wdata;
  logic          c_we;
  logic [3:0]    c_wstrb;
  logic [31:0]   mem [logic [31:0]];

  assign mem_rvalid = m_rv | spur_rv;

  task automatic do_gnt();
    logic [31:0] w;
    mem_gnt = 1'b1;
    phase   = 2;
    cnt     = 0;
    if (c_we) begin
      w = mem.exists(c_addr) ? mem[c_addr] : 32'h0;
      for (int b = 0; b < 4; b++)
        if (c_wstrb[b]) w[b*8 +: 8] = c_wdata[b*8 +: 8];
      mem[c_addr] = w;
    end
  endtask

  initial begin
    mem_gnt   = 1'b0;
    m_rv      = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      mem_gnt = 1'b0;
      m_rv    = 1'b0;
      if (rst) begin
        phase = 0;
      end else begin
        case (phase)
          0: if (mem_req) begin
               c_addr = mem_addr; c_we = mem_we; c_wdata = mem_wdata; c_wstrb = mem_wstrb;
               cnt = 0;
               if (gnt_delay == 0) do_gnt();
               else phase = 1;
             end
          1: begin
               check("cmd_stable_req", {31'b0, mem_req}, 32'd1);
               check("cmd_stable_addr", mem_addr, c_addr);
               check("cmd_stable_we", {31'b0, mem_we}, {31'b0, c_we});
               check("cmd_stable_wdata", mem_wdata, c_wdata);
               cnt++;
               if (cnt == gnt_delay) do_gnt();
             end
          2: begin
               if (cnt == rv_delay) begin
                 m_rv      = 1'b1;
                 mem_rdata = c_we ? 32'h5A5A5A5A :
                             (mem.exists(c_addr) ? mem[c_addr] : 32'hBAD0BAD0);
                 phase     = 0;
               end else begin
                 cnt++;
               end
             end
          default: phase = 0;
        endcase
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input bit is_d, input int limit, input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < limit && !seen; k++) begin
      @(negedge clk);
      if (is_d ? d_valid : i_valid) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: no valid within %0d cycles", name, limit);
    end
  endtask

  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] exp, input string name);
    tick();
    i_req = 1'b1; i_addr = addr;
    push_exp(1'b0, 1'b1, exp, name);
    wait_valid(1'b0, 100, name);
    tick();
    i_req = 1'b0;
  endtask

  task automatic do_data(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic [31:0] exp, input string name);
    tick();
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_wstrb = wstrb;
    push_exp(1'b1, !we, exp, name);
    wait_valid(1'b1, 100, name);
    tick();
    d_req = 1'b0;
  endtask

  // Bound the whole run even if a wait above misbehaves.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int n_req_cycles;
    bit seen_req;

    rst = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    mem[32'h100] = 32'h00500093;
    mem[32'h300] = 32'h11111111;
    mem[32'h400] = 32'h22222222;

    // reset state, before any clock edge
    #1;
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
    check("rst_protocol_err", {31'b0, protocol_err}, 32'd0);
    check("rst_valids", {30'b0, i_valid, d_valid}, 32'd0);
    check("rst_stalls", {30'b0, i_stall, d_stall}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // single fetch, cycle accurate: mem_req in cycle 1, i_valid in cycle 2
    tick();
    i_req = 1'b1; i_addr = 32'h100;
    push_exp(1'b0, 1'b1, 32'h00500093, "fetch1");
    @(negedge clk);
    check("f1_c0_mem_req", {31'b0, mem_req}, 32'd0);
    check("f1_c0_i_stall", {31'b0, i_stall}, 32'd1);
    @(negedge clk);
    check("f1_c1_mem_req", {31'b0, mem_req}, 32'd1);
    check("f1_c1_mem_addr", mem_addr, 32'h100);
    check("f1_c1_mem_we", {31'b0, mem_we}, 32'd0);
    check("f1_c1_mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
    check("f1_c1_i_stall", {31'b0, i_stall}, 32'd1);
    @(negedge clk);
    check("f1_c2_i_valid", {31'b0, i_valid}, 32'd1);
    check("f1_c2_mem_req", {31'b0, mem_req}, 32'd0);
    check("f1_c2_i_stall", {31'b0, i_stall}, 32'd0);
    tick();
    i_req = 1'b0;

    // store with grant in the third mem_req cycle
    gnt_delay = 2;
    tick();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF;
    push_exp(1'b1, 1'b0, 32'h0, "store1");
    n_req_cycles = 0;
    seen_req = 1'b0;
    for (int k = 0; k < 20 && !seen_req; k++) begin
      @(negedge clk);
      if (mem_req) begin
        n_req_cycles++;
        if (n_req_cycles == 1) begin
          check("st_mem_we", {31'b0, mem_we}, 32'd1);
          check("st_mem_addr", mem_addr, 32'h2000);
          check("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
          check("st_mem_wstrb", {28'b0, mem_wstrb}, 32'hF);
        end
      end
      if (d_valid) seen_req = 1'b1;
    end
    check("st_d_valid_seen", {31'b0, seen_req}, 32'd1);
    check("st_mem_req_cycles", n_req_cycles, 32'd3);
    tick();
    d_req = 1'b0;
    gnt_delay = 0;

    // partial store merges into the word, then load it back
    do_data(1'b1, 32'h2000, 32'h00001234, 4'b0011, 32'h0, "store2");
    do_data(1'b0, 32'h2000, 32'h0, 4'h0, 32'hDEAD1234, "load_merge");

    // fetch with delayed grant and delayed response
    @(negedge clk);
    gnt_delay = 1; rv_delay = 3;
    do_fetch(32'h300, 32'h11111111, "fetch_slow");
    @(negedge clk);
    gnt_delay = 0; rv_delay = 0;

    // contention: expected grant order D,D,D,D,I,D,D,D,D,I
    for (int k = 0; k < 10; k++) begin
      if (k == 4 || k == 9) push_exp(1'b0, 1'b1, 32'h11111111, $sformatf("cont%0d_I", k));
      else                  push_exp(1'b1, 1'b1, 32'h22222222, $sformatf("cont%0d_D", k));
    end
    fork
      begin
        tick();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
        for (int k = 0; k < 8; k++) wait_valid(1'b1, 60, "cont_d");
        tick();
        d_req = 1'b0;
      end
      begin
        tick();
        i_req = 1'b1; i_addr = 32'h300;
        for (int k = 0; k < 2; k++) wait_valid(1'b0, 60, "cont_i");
        tick();
        i_req = 1'b0;
      end
    join
    check("cont_all_served", exp_q.size(), 32'd0);

    // reset while waiting for a load response
    @(negedge clk);
    rv_delay = 1000;
    tick();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    push_exp(1'b1, 1'b1, 32'h22222222, "load_abandoned");
    seen_req = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_req) seen_req = 1'b1;
      else if (seen_req) break;
    end
    check("rw_in_wait", {31'b0, seen_req & ~mem_req}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("rw_mem_req", {31'b0, mem_req}, 32'd0);
    check("rw_mem_addr", mem_addr, 32'd0);
    check("rw_mem_we", {31'b0, mem_we}, 32'd0);
    check("rw_mem_wdata", mem_wdata, 32'd0);
    check("rw_mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
    check("rw_d_valid", {31'b0, d_valid}, 32'd0);
    d_req = 1'b0;
    rv_delay = 0;
    tick();
    tick();
    rst = 1'b0;
    do_fetch(32'h100, 32'h00500093, "fetch_after_rst");

    // spurious response in IDLE
    @(negedge clk);
    check("sp_err_before", {31'b0, protocol_err}, 32'd0);
    tick();
    spur_rv = 1'b1;
    @(negedge clk);
    check("sp_no_valid", {30'b0, i_valid, d_valid}, 32'd0);
    tick();
    spur_rv = 1'b0;
    @(negedge clk);
    check("sp_err_set", {31'b0, protocol_err}, 32'd1);
    repeat (3) tick();
    check("sp_err_sticky", {31'b0, protocol_err}, 32'd1);
    do_fetch(32'h300, 32'h11111111, "fetch_with_err");
    check("sp_err_still", {31'b0, protocol_err}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("sp_err_cleared", {31'b0, protocol_err}, 32'd0);
    tick();
    rst = 1'b0;

    repeat (3) tick();
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
